// File: rtl/video_rx.sv
// Parallel RGB (DE/HS/VS) receiver: geometry check, lock FSM, windowed decimation into pixel writes.
// Optional VIDEO_RX_ERRCNT_EN builds a saturating error counter on err_count.
module video_rx #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 144,
  parameter int XDIV        = 3,
  parameter int YDIV        = 3,
  parameter int XSTART      = 80,
  parameter int YSTART      = 24,
  parameter int HSIZE       = 640,
  parameter int VSIZE       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clock25,
  input  logic        reset,
  input  logic [23:0] VID_D,
  input  logic        VID_DE,
  input  logic        VID_HS,
  input  logic        VID_VS,
  output logic        wr_en,
  output logic [11:0] wr_x,
  output logic [11:0] wr_y,
  output logic [7:0]  wr_r,
  output logic [7:0]  wr_g,
  output logic [7:0]  wr_b,
  output logic        frame_start,
  output logic        frame_done,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {UNLOCKED, SYNC, LOCKED} state_t;

  localparam logic [11:0] HSIZE_W = 12'(HSIZE);
  localparam logic [11:0] VSIZE_W = 12'(VSIZE);
  localparam logic [12:0] XLO     = 13'(XSTART);
  localparam logic [12:0] XHI     = 13'(XSTART + XDIV * WIDTH);
  localparam logic [12:0] YLO     = 13'(YSTART);
  localparam logic [12:0] YHI     = 13'(YSTART + YDIV * HEIGHT);
  localparam logic [11:0] XPH_MAX = 12'(XDIV - 1);
  localparam logic [11:0] YPH_MAX = 12'(YDIV - 1);
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  logic [23:0] s1_d;
  logic        s1_de, s1_hs, s1_vs, p_de, p_vs;
  logic [11:0] col, row, xph, yph, x_cnt, y_cnt;
  logic        line_kept;
  state_t      state, state_n, st_mid;
  logic [7:0]  good, good_n;
  logic        err_n, done_n;

  logic        de_rise, de_fall, vs_rise;
  logic [11:0] cur_col, col_inc, row_inc, row_eff, cur_xph;
  logic        line_err, frame_err, in_win, in_ywin, keep, write;
  logic        unused_hs;

  assign unused_hs = s1_hs;

  always_ff @(posedge clock25) begin
    if (reset) begin
      s1_d <= '0; s1_de <= 1'b0; s1_hs <= 1'b0; s1_vs <= 1'b0;
      p_de <= 1'b0; p_vs <= 1'b0;
    end else begin
      s1_d <= VID_D; s1_de <= VID_DE; s1_hs <= VID_HS; s1_vs <= VID_VS;
      p_de <= s1_de; p_vs <= s1_vs;
    end
  end

  assign de_rise   = s1_de & ~p_de;
  assign de_fall   = ~s1_de & p_de;
  assign vs_rise   = s1_vs & ~p_vs;
  assign cur_col   = de_rise ? '0 : col;
  assign col_inc   = (cur_col == '1) ? cur_col : cur_col + 12'd1;
  assign row_inc   = (row == '1) ? row : row + 12'd1;
  // Frame check sees the row count after a coincident DE fall.
  assign row_eff   = de_fall ? row_inc : row;
  assign line_err  = de_fall && (col != HSIZE_W);
  assign frame_err = vs_rise && (row_eff != VSIZE_W);
  assign in_ywin   = ({1'b0, row} >= YLO) && ({1'b0, row} < YHI);
  assign in_win    = s1_de && ({1'b0, cur_col} >= XLO) && ({1'b0, cur_col} < XHI) && in_ywin;
  assign cur_xph   = ({1'b0, cur_col} == XLO) ? '0 : xph;
  assign keep      = in_win && (cur_xph == '0) && (yph == '0);
  assign write     = keep && (state == LOCKED);

  always_ff @(posedge clock25) begin
    if (reset) begin
      col <= '0; row <= '0; xph <= '0; yph <= '0;
      x_cnt <= '0; y_cnt <= '0; line_kept <= 1'b0;
    end else begin
      if (s1_de) col <= col_inc;
      if (in_win) xph <= (cur_xph == XPH_MAX) ? '0 : cur_xph + 12'd1;
      if (keep) begin
        x_cnt     <= x_cnt + 12'd1;
        line_kept <= 1'b1;
      end
      if (de_fall) begin
        row       <= row_inc;
        x_cnt     <= '0;
        line_kept <= 1'b0;
        if (line_kept) y_cnt <= y_cnt + 12'd1;
        if ({1'b0, row_inc} == YLO) yph <= '0;
        else if (in_ywin) yph <= (yph == YPH_MAX) ? '0 : yph + 12'd1;
      end
      if (vs_rise) begin
        row <= '0; col <= '0; yph <= '0;
        x_cnt <= '0; y_cnt <= '0; line_kept <= 1'b0;
      end
    end
  end

  // Line check resolves first; a VS rise in the same cycle then acts on the resulting state.
  always_comb begin
    st_mid = state;
    good_n = good;
    err_n  = 1'b0;
    done_n = 1'b0;
    if (line_err && state != UNLOCKED) begin
      err_n  = 1'b1;
      st_mid = UNLOCKED;
    end
    state_n = st_mid;
    if (vs_rise) begin
      case (st_mid)
        UNLOCKED: begin
          state_n = SYNC;
          good_n  = '0;
        end
        SYNC: begin
          if (frame_err) begin
            err_n   = 1'b1;
            state_n = UNLOCKED;
          end else begin
            good_n = good + 8'd1;
            if (good + 8'd1 >= LOCK_N) state_n = LOCKED;
          end
        end
        default: begin
          if (frame_err) begin
            err_n   = 1'b1;
            state_n = UNLOCKED;
          end else begin
            done_n = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock25) begin
    if (reset) begin
      state <= UNLOCKED; good <= '0;
      err <= 1'b0; frame_done <= 1'b0; wr_en <= 1'b0; frame_start <= 1'b0;
      wr_x <= '0; wr_y <= '0; wr_r <= '0; wr_g <= '0; wr_b <= '0;
    end else begin
      state       <= state_n;
      good        <= good_n;
      err         <= err_n;
      frame_done  <= done_n;
      wr_en       <= write;
      frame_start <= write && (x_cnt == '0) && (y_cnt == '0);
      if (write) begin
        wr_x <= x_cnt;
        wr_y <= y_cnt;
        wr_r <= s1_d[23:16];
        wr_g <= s1_d[15:8];
        wr_b <= s1_d[7:0];
      end
    end
  end

  assign locked = (state == LOCKED);

`ifdef VIDEO_RX_ERRCNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clock25) begin
    if (reset) err_cnt_q <= '0;
    else if (err_n && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule
